// File: rtl/fetch_pkg.sv
// Encodings shared between the instruction fetcher and the core scheduler.
package fetch_pkg;

    localparam logic [2:0] IDLE     = 3'b000;
    localparam logic [2:0] FETCHING = 3'b001;
    localparam logic [2:0] FETCHED  = 3'b010;

    localparam logic [2:0] FETCH  = 3'b001;
    localparam logic [2:0] DECODE = 3'b010;
    localparam logic [2:0] DONE   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE     = IDLE,
        S_FETCHING = FETCHING,
        S_FETCHED  = FETCHED
    } fetcher_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO: head_data is combinational from the head slot, count updates next edge.
// No internal backpressure; the owner must not push when full nor pop when empty. Flush beats push/pop.
module fetch_queue #(
    parameter int DEPTH     = 4,
    parameter int DATA_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_BITS-1:0]   push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [DATA_BITS-1:0]   head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_BITS-1:0] slots [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;

    assign head_data = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with sequential prefetch: queue hit serves in 1 cycle, miss costs one memory round trip.
// Holds mem_read_valid until mem_read_ready; at most one read outstanding, issue stalls while the queue is full.
module prefetch_fetcher import fetch_pkg::*; #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int DEPTH                 = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int CW = $clog2(DEPTH) + 1;

    fetcher_state_e                   state;
    logic [A-1:0]                     head_pc;
    logic                             drop;
    logic                             primed;
    logic [CW-1:0]                    count;
    logic [PROGRAM_MEM_DATA_BITS-1:0] head_data;

    // The single outstanding request is exactly the time valid is held high.
    logic in_flight;
    assign in_flight = mem_read_valid;

    logic accept, fetch_req, hit, miss, bypass, push, issue;
    assign accept    = mem_read_valid && mem_read_ready;
    assign fetch_req = (state == S_IDLE) && (core_state == FETCH);
    assign hit       = fetch_req && (count != '0) && (head_pc == current_pc);
    assign miss      = fetch_req && !hit;
    assign bypass    = (state == S_FETCHING) && accept && !drop;
    assign push      = accept && !drop && (state != S_FETCHING);
    // Nothing is streamed until the core has named a PC after reset.
    assign issue     = primed && !in_flight && (count < CW'(DEPTH)) &&
                       (core_state != DONE) && !miss;

    assign fetcher_state = state;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .DATA_BITS(PROGRAM_MEM_DATA_BITS)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(mem_read_data),
        .pop      (hit),
        .flush    (miss),
        .head_data(head_data),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            head_pc          <= '0;
            drop             <= 1'b0;
            primed           <= 1'b0;
        end else begin
            if (accept) begin
                mem_read_valid <= 1'b0;
                drop           <= 1'b0;
            end
            if (issue) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= head_pc + A'(count);
            end
            // Stale response gone: reissue the branch target with no idle gap.
            if (accept && drop) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= head_pc;
            end

            case (state)
                S_IDLE: begin
                    if (fetch_req) begin
                        primed <= 1'b1;
                        if (hit) begin
                            instruction <= head_data;
                            head_pc     <= head_pc + A'(1);
                            state       <= S_FETCHED;
                        end else begin
                            head_pc <= current_pc;
                            state   <= S_FETCHING;
                            if (in_flight && !mem_read_ready) begin
                                drop <= 1'b1;
                            end else begin
                                mem_read_valid   <= 1'b1;
                                mem_read_address <= current_pc;
                            end
                        end
                    end
                end
                S_FETCHING: begin
                    if (bypass) begin
                        instruction <= mem_read_data;
                        head_pc     <= head_pc + A'(1);
                        state       <= S_FETCHED;
                    end
                end
                S_FETCHED: begin
                    if (core_state == DECODE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/prefetch_fetcher.md
# prefetch_fetcher

Per-core instruction fetcher with a parametrised prefetch queue. While the core decodes and executes, it streams sequential instructions from program memory into a DEPTH-entry circular buffer. A FETCH whose PC matches the queue head is served in one cycle; a PC mismatch (branch or jump) flushes the queue and restarts the stream at the new PC. It sits between the core scheduler and the program-memory controller, and keeps the three-state fetcher status encoding the scheduler already uses.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, program address width; also the width of the PC.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- DEPTH, 4, number of prefetch queue entries; must be a power of 2 and ≥ 2.

- clk  in  1  clock. One clock domain only.
- reset  in  1  synchronous, active-high reset.
- core_state  in  3  core stage: 3'b001 FETCH, 3'b010 DECODE, 3'b111 DONE.
- current_pc  in  ADDR_BITS  PC to fetch.
- mem_read_valid  out  1  read request; held high until accepted.
- mem_read_address  out  ADDR_BITS  request address; stable while valid is high.
- mem_read_ready  in  1  request accepted; mem_read_data is valid in the same cycle.
- mem_read_data  in  DATA_BITS  returned instruction.
- fetcher_state  out  3  3'b000 IDLE, 3'b001 FETCHING, 3'b010 FETCHED.
- instruction  out  DATA_BITS  fetched instruction; valid while fetcher_state is FETCHED.

## Operation
- **Queue contents:** consecutive instructions starting at head_pc. Entry i holds address head_pc+i, mod 2^ADDR_BITS (addresses wrap 0xFF→0x00 at the default width).
- **Queue state:** count is 0..DEPTH. in_flight is 1 while a request is outstanding. At most one request is outstanding at any time.
- **Prefetch issue:** a request for address head_pc+count is issued when all of the following hold:
  - in_flight=0
  - count < DEPTH
  - core_state ≠ DONE
  - no FETCH miss is being processed in this cycle
- **Response:** on valid&&ready, the entry is pushed unless the drop flag is set, in_flight clears, and mem_read_valid drops on the next edge.
- **Fetch FSM:**
  - **IDLE:**
    - Action only when core_state=FETCH.
    - Hit (count>0 and head_pc==current_pc): instruction ← head entry, pop (head_pc+1, count−1), go to FETCHED.
    - Otherwise, miss: flush (count←0, head_pc←current_pc) and go to FETCHING.
      - If a request is in flight, set drop. Do not retract mem_read_valid; the returning response is discarded and drop clears on its acceptance.
      - If nothing is in flight, request current_pc on the next edge.
  - **FETCHING:**
    - On the first non-dropped response: instruction ← data directly (bypass, not enqueued), head_pc+1, go to FETCHED.
  - **FETCHED:** go to IDLE when core_state=DECODE.
- **Simultaneous push and pop:** legal; count is unchanged.
- **Full queue:** issue stalls and no data is lost.
- **DONE:** outstanding requests complete normally; no new requests are issued.

## Timing
- **Reset values (next edge):**
  - fetcher_state=IDLE
  - mem_read_valid=0
  - mem_read_address=0
  - instruction=0
  - count=0, in_flight=0, drop=0, head_pc=0
- Reset mid-transaction abandons the transaction; the memory side must tolerate the withdrawn valid.
- **Hit:** FETCH sampled in IDLE at edge t → FETCHED at t+1. 1-cycle latency.
- **Miss, nothing in flight:**
  - mem_read_valid=1 from t+1.
  - ready at edge r → FETCHED at r+1.
  - Matches the non-prefetching fetcher.
- **Miss with a request in flight:** the in-flight accept at edge r is dropped. The new request is valid from r+1.
- **Prefetch spacing:** back-to-back requests need 1 cycle of valid low between them, so peak throughput is 1 instruction per 2 cycles.

## Structure
- **Shared package `fetch_pkg`:**
  - fetcher_state localparams IDLE/FETCHING/FETCHED.
  - core_state codes FETCH/DECODE/DONE.
  - Both are reused by the scheduler.
- **Sub-module `fetch_queue`:** parametrised circular FIFO (DEPTH × DATA_BITS).
  - Ports: push, pop, flush, head data, count.
  - Pointer width is $clog2(DEPTH); count width is $clog2(DEPTH)+1.
  - Flush has priority over push/pop in the same cycle.
- **prefetch_fetcher itself** holds head_pc, in_flight/drop, the issue logic and the FSM.

## Test plan
- **Cold start:** reset, FETCH at pc=0x00, ready after 3 cycles with data 0x1234 → FETCHED, instruction=0x1234; prefetch then fills entries 0x01..0x04 (DEPTH=4) and stalls with count=4.
- **Sequential hits:** after the fill, FETCH pc=0x01 → FETCHED one cycle later with the 0x01 data; count=3, and a refill request for 0x05 issues.
- **Branch miss with request in flight:** request for 0x03 pending, FETCH pc=0x40 → the 0x03 response is dropped, the next request address is 0x40, and instruction is the 0x40 data.
- **Wrap:** head_pc=0xFE, DEPTH=4 → requests 0xFE, 0xFF, 0x00, 0x01 in that order.
- **Reset:** assert reset while mem_read_valid=1 with a FETCH pending → next edge gives all outputs 0, count=0, and no request until the next FETCH.
- **DONE:** core_state=DONE with the queue partially full → no new mem_read_valid rises after the in-flight accept.
